axi_instr_mem_slave: RTL
========================

Name: axi_instr_mem_slave

Overview:
Synthesizable AXI4 read-only slave memory that answers instruction fetches from the simple cache's AXI master. It replaces the behavioural slave VIP in hardware builds and on-chip test setups. Contents are preloaded through a word-wide init port, and bursts are served from an internal word array.

Parameters:
ADDR_WIDTH, 32, byte-address width of ARADDR and init_addr
DATA_WIDTH, 32, data beat width; all beats are full width
ID_WIDTH, 4, width of ARID/RID
MEM_WORDS, 256, depth of word array; byte range 0 .. MEM_WORDS*DATA_WIDTH/8-1
READ_LATENCY, 1, extra wait cycles before the first R beat of each burst (0..15)

Ports:
clk  in  1  system clock
rst  in  1  reset
init_en  in  1  preload write strobe; one word per cycle
init_addr  in  ADDR_WIDTH  preload byte address, word aligned
init_data  in  DATA_WIDTH  preload data
s_axi_arid  in  ID_WIDTH  read transaction ID
s_axi_araddr  in  ADDR_WIDTH  burst start byte address
s_axi_arlen  in  8  beats minus one
s_axi_arburst  in  2  00 FIXED, 01 INCR, 10 WRAP
s_axi_arvalid  in  1  AR valid
s_axi_arready  out  1  AR ready
s_axi_rid  out  ID_WIDTH  echoed ARID
s_axi_rdata  out  DATA_WIDTH  read data
s_axi_rresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
s_axi_rlast  out  1  final beat
s_axi_rvalid  out  1  R valid
s_axi_rready  in  1  R ready

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, synchronous and active-high.
- Reset values: arready=0, rvalid=0, rlast=0, rdata=0, rresp=0, rid=0, FSM=IDLE. Memory contents are retained across reset.
- FSM states: IDLE, WAIT, BURST.
  - IDLE: arready=1 (registered; rises the first cycle after rst falls).
  - AR handshake (arvalid & arready) at cycle T: latch id, addr, len, burst; arready drops at T+1.
  - Go to WAIT if READ_LATENCY>0, otherwise straight to BURST.
- WAIT: counts READ_LATENCY cycles. The first beat has rvalid=1 at T+1+READ_LATENCY.
- BURST:
  - A beat completes on rvalid & rready.
  - rdata, rresp, rlast and rid stay stable while rvalid & !rready.
  - Next beat is presented the cycle after a handshake (back-to-back throughput, 1 beat/cycle).
  - rlast=1 on beat index == len.
  - After the last handshake, go to IDLE; arready=1 the next cycle. Only one burst is outstanding.
- Address generation (word index = addr >> log2(DATA_WIDTH/8)):
  - FIXED: address is constant for all beats.
  - INCR: address +1 word per beat. No 4KB check; wraps modulo 2^ADDR_WIDTH.
  - WRAP: legal only for len in {1,3,7,15}. Wrap boundary = addr aligned down to (len+1) words; the next index wraps inside that window.
- Errors:
  - Illegal WRAP length → every beat returns SLVERR, rdata=0, and the full len+1 beats are still issued.
  - Beat address ≥ MEM_WORDS → that beat returns DECERR, rdata=0. Other beats in the burst are unaffected.
- Reads are read-first. An init write in the same cycle a beat's data is fetched returns the old word; the new word is visible one cycle later.
- Init port:
  - Usable in any state; has no handshake.
  - Out-of-range init_addr is silently dropped.
  - Low address bits below word alignment are ignored.
- Reset mid-burst: rvalid drops the cycle after rst is sampled high and the burst is abandoned (no rlast). The master is reset alongside.
- Memory is inferred as a single-port-read plus single-port-write array; the read data register doubles as the output register.

Decomposition:
- Package axi_slave_pkg:
  - burst_t enum (FIXED/INCR/WRAP/RSVD); reserved 11 is treated as INCR.
  - resp codes RESP_OKAY/RESP_SLVERR/RESP_DECERR.
  - rd_state_t enum {IDLE, WAIT, BURST}.
- Sub-module axi_burst_addr_gen: combinational next-word-index and wrap-legal flag from (cur_idx, start_idx, len, burst). Reusable by a future write slave.

Test Plan:
1. Preload word 0x80→32'h2400006f. AR INCR addr 0x200, len 0, rready=1, READ_LATENCY=1 → single beat rdata=32'h2400006f, rresp=00, rlast=1 at T+2; arready returns to 1 at T+3.
2. Preload words 128..131 = fe010113, 00112e23, 00812c23, 02010413. AR INCR addr 0x200, len 3 → 4 consecutive beats in that order, rlast only on the 4th, rid echoes arid=4'h5.
3. Same burst with rready toggled 1,0,0,1,… → no beat lost or duplicated; rdata held stable through stall cycles.
4. WRAP addr 0x208, len 3 → beats read words 130,131,128,129. WRAP with len 2 → three beats, all SLVERR, rdata=0.
5. INCR addr (MEM_WORDS-2)*4, len 3 → beats 1–2 OKAY with data, beats 3–4 DECERR, rdata=0, rlast on beat 4.
6. rst pulsed during beat 2 of a len-7 burst → rvalid=0 next cycle; after rst releases, arready=1 and a new len-0 read of word 128 returns fe010113 (contents retained).

Source files
------------

// File: rtl/axi_slave_pkg.sv
// Shared AXI read-slave types: burst encodings, response codes, read FSM states
// and the WRAP length legality helper.
package axi_slave_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST
    } rd_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Burst control captured at the AR handshake
    typedef struct packed {
        logic [7:0] len;
        burst_t     burst;
    } ar_ctl_t;

    function automatic logic wrap_len_legal(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_instr_mem_slave_if.sv
// AXI4 read-address and read-data channels between instruction-fetch master and slave.
interface axi_instr_mem_slave_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;
    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport slave (
        input  arid, araddr, arlen, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );

    modport master (
        output arid, araddr, arlen, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI burst word-index stepper (FIXED/INCR/WRAP) plus WRAP length check.
module axi_burst_addr_gen
    import axi_slave_pkg::*;
#(
    parameter int unsigned IDX_W = 30
) (
    input  logic [IDX_W-1:0] cur_idx_i,
    input  logic [IDX_W-1:0] start_idx_i,
    input  logic [7:0]       len_i,
    input  burst_t           burst_i,
    output logic [IDX_W-1:0] next_idx_c_o,
    output logic             wrap_legal_c_o
);

    logic [IDX_W-1:0] mask_c;
    logic [IDX_W-1:0] inc_c;

    always_comb begin
        mask_c         = IDX_W'(len_i);
        inc_c          = cur_idx_i + IDX_W'(1);
        wrap_legal_c_o = wrap_len_legal(len_i);
        next_idx_c_o   = inc_c;
        case (burst_i)
            BURST_FIXED: next_idx_c_o = cur_idx_i;
            // Legal WRAP lengths make len+1 a power of two, so len is the window mask
            BURST_WRAP: begin
                if (wrap_legal_c_o) begin
                    next_idx_c_o = (start_idx_i & ~mask_c) | (inc_c & mask_c);
                end
            end
            default:     next_idx_c_o = inc_c;
        endcase
    end

endmodule

// File: rtl/axi_instr_mem_slave.sv
// AXI4 read-only instruction memory slave with word-wide preload port and
// configurable first-beat latency; one burst outstanding at a time.
module axi_instr_mem_slave
    import axi_slave_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ID_WIDTH     = 4,
    parameter int unsigned MEM_WORDS    = 256,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init_en,
    input  logic [ADDR_WIDTH-1:0] init_addr,
    input  logic [DATA_WIDTH-1:0] init_data,
    axi_instr_mem_slave_if.slave  s_axi
);

    localparam int unsigned OFF   = $clog2(DATA_WIDTH / 8);
    localparam int unsigned IDX_W = ADDR_WIDTH - OFF;
    localparam int unsigned MW_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [3:0]  LAT_LAST = 4'(READ_LATENCY - 1);

    logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

    rd_state_t             state_q;
    logic                  arready_q;
    logic                  rvalid_q;
    logic                  rlast_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;
    logic [ID_WIDTH-1:0]   rid_q;
    logic [IDX_W-1:0]      start_idx_q;
    logic [IDX_W-1:0]      cur_idx_q;
    ar_ctl_t               ctl_q;
    logic                  slverr_q;
    logic [7:0]            beat_q;
    logic [3:0]            wcnt_q;

    logic [IDX_W-1:0]      init_idx_c;
    logic [IDX_W-1:0]      ar_idx_c;
    burst_t                ar_burst_c;
    logic                  ar_hs_c;
    logic                  ar_slverr_c;
    logic [IDX_W-1:0]      gen_cur_c;
    logic [IDX_W-1:0]      gen_start_c;
    logic [7:0]            gen_len_c;
    burst_t                gen_burst_c;
    logic [IDX_W-1:0]      gen_next_c;
    logic                  gen_wrap_legal_c;
    logic [IDX_W-1:0]      fetch_idx_c;
    logic [7:0]            fetch_beat_c;
    logic                  fetch_slverr_c;
    logic [DATA_WIDTH-1:0] rdata_d;
    logic [1:0]            rresp_d;
    logic                  rlast_d;
    logic                  unused_low_bits;

    assign unused_low_bits = ^{s_axi.araddr[OFF-1:0], init_addr[OFF-1:0]};

    // Preload port; out-of-range words are dropped
    assign init_idx_c = init_addr[ADDR_WIDTH-1:OFF];
    always_ff @(posedge clk) begin
        if (init_en && (init_idx_c < IDX_W'(MEM_WORDS))) begin
            mem_q[init_idx_c[MW_W-1:0]] <= init_data;
        end
    end

    axi_burst_addr_gen #(
        .IDX_W (IDX_W)
    ) u_addr_gen (
        .cur_idx_i      (gen_cur_c),
        .start_idx_i    (gen_start_c),
        .len_i          (gen_len_c),
        .burst_i        (gen_burst_c),
        .next_idx_c_o   (gen_next_c),
        .wrap_legal_c_o (gen_wrap_legal_c)
    );

    // Select the beat to fetch next: first beat from AR (IDLE) or latched start (WAIT)
    always_comb begin
        ar_idx_c       = s_axi.araddr[ADDR_WIDTH-1:OFF];
        ar_burst_c     = burst_t'(s_axi.arburst);
        ar_hs_c        = (state_q == IDLE) && s_axi.arvalid && arready_q;
        gen_cur_c      = cur_idx_q;
        gen_start_c    = start_idx_q;
        gen_len_c      = ctl_q.len;
        gen_burst_c    = ctl_q.burst;
        fetch_idx_c    = gen_next_c;
        fetch_beat_c   = beat_q + 8'd1;
        fetch_slverr_c = slverr_q;
        if (state_q == IDLE) begin
            gen_cur_c   = ar_idx_c;
            gen_start_c = ar_idx_c;
            gen_len_c   = s_axi.arlen;
            gen_burst_c = ar_burst_c;
        end
        ar_slverr_c = (ar_burst_c == BURST_WRAP) && !gen_wrap_legal_c;
        case (state_q)
            IDLE: begin
                fetch_idx_c    = ar_idx_c;
                fetch_beat_c   = 8'd0;
                fetch_slverr_c = ar_slverr_c;
            end
            WAIT: begin
                fetch_idx_c  = start_idx_q;
                fetch_beat_c = 8'd0;
            end
            default: ;
        endcase
        rlast_d = (fetch_beat_c == gen_len_c);
        rdata_d = '0;
        rresp_d = RESP_OKAY;
        if (fetch_slverr_c) begin
            rresp_d = RESP_SLVERR;
        end else if (fetch_idx_c >= IDX_W'(MEM_WORDS)) begin
            rresp_d = RESP_DECERR;
        end else begin
            rdata_d = mem_q[fetch_idx_c[MW_W-1:0]];
        end
    end

    // Read FSM; the R-channel registers are loaded only when a new beat is presented
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            arready_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rlast_q     <= 1'b0;
            rdata_q     <= '0;
            rresp_q     <= RESP_OKAY;
            rid_q       <= '0;
            start_idx_q <= '0;
            cur_idx_q   <= '0;
            ctl_q       <= '0;
            slverr_q    <= 1'b0;
            beat_q      <= '0;
            wcnt_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    arready_q <= 1'b1;
                    if (ar_hs_c) begin
                        arready_q   <= 1'b0;
                        rid_q       <= s_axi.arid;
                        start_idx_q <= ar_idx_c;
                        cur_idx_q   <= ar_idx_c;
                        ctl_q       <= '{len: s_axi.arlen, burst: ar_burst_c};
                        slverr_q    <= ar_slverr_c;
                        wcnt_q      <= '0;
                        if (READ_LATENCY == 0) begin
                            state_q  <= BURST;
                            rvalid_q <= 1'b1;
                            rdata_q  <= rdata_d;
                            rresp_q  <= rresp_d;
                            rlast_q  <= rlast_d;
                            beat_q   <= fetch_beat_c;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    wcnt_q <= wcnt_q + 4'd1;
                    if (wcnt_q == LAT_LAST) begin
                        state_q   <= BURST;
                        rvalid_q  <= 1'b1;
                        rdata_q   <= rdata_d;
                        rresp_q   <= rresp_d;
                        rlast_q   <= rlast_d;
                        beat_q    <= fetch_beat_c;
                        cur_idx_q <= fetch_idx_c;
                    end
                end
                BURST: begin
                    if (rvalid_q && s_axi.rready) begin
                        if (rlast_q) begin
                            state_q   <= IDLE;
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            arready_q <= 1'b1;
                        end else begin
                            rdata_q   <= rdata_d;
                            rresp_q   <= rresp_d;
                            rlast_q   <= rlast_d;
                            beat_q    <= fetch_beat_c;
                            cur_idx_q <= fetch_idx_c;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rlast   = rlast_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rid     = rid_q;

endmodule
